spi0_arbiter: RTL and testbench
===============================

# spi0_arbiter

Shares the single SPI0 port between two byte-oriented requesters: the 6502 SPI peripheral (requester 0) and the flash boot/DMA loader (requester 1). It performs round-robin arbitration per transaction, holds chip-select low for the whole granted transaction, and runs an SPI mode-0 byte engine on the 40 MHz clk_4x domain. It sits between the system core and the spi0_* pads.

## Interface
- CLK_DIV, 2: clk_4x cycles per SCLK half-period, legal range 1..15. SCLK = clk_4x/(2*CLK_DIV).
- CS_GAP, 4: minimum clk_4x cycles cs_n stays high between transactions, legal range 1..15.

Ports:
- clk_4x  in  1  clock, 40 MHz PLL output.
- NRST  in  1  reset: synchronous, active-low, on clk_4x.
- req0, req1  in  1  transaction request. Held high for the whole transaction.
- wr0, wr1  in  1  one-cycle byte start strobe. Honoured only while the matching gnt is high and the engine is idle.
- tx0, tx1  in  8  byte to send, sampled on the cycle wr is high.
- gnt0, gnt1  out  1  grant. One-hot or zero.
- done0, done1  out  1  one-cycle pulse when a byte completes for that requester.
- rx_data  out  8  last received byte. Valid from done until the next done.
- busy  out  1  high in every state except IDLE.
- spi_sclk  out  1  SPI clock, mode 0 (idles low).
- spi_mosi  out  1  MSB first.
- spi_miso  in  1  serial data in.
- spi_cs_n  out  1  chip select, active low.

## Operation
- FSM states:
  - IDLE: cs_n=1. Grants when any req is high.
    - Only one request high → that requester is granted.
    - Both high → the requester not granted last time wins. last_gnt resets to 1, so req0 wins the first tie.
  - GRANT: cs_n=0, gnt held.
    - A wr from the granted requester → SHIFT.
    - The granted req low → GAP.
    - A wr from the non-granted requester is ignored; no done is produced.
  - SHIFT: 8 bits are transferred. Then:
    - done pulses for the granted requester and rx_data is updated.
    - Return to GRANT if the granted req is still high, otherwise go to GAP.
    - If req drops mid-byte, the byte still completes and done still pulses.
    - A wr during SHIFT is ignored.
  - GAP: cs_n=1, gnt=0. Hold for CS_GAP cycles, then IDLE.
- Byte engine, mode 0, MSB first:
  - mosi is loaded with tx[7] on SHIFT entry.
  - After CLK_DIV cycles sclk rises and miso is sampled into the shift register LSB.
  - After CLK_DIV more cycles sclk falls and mosi advances to the next bit.
  - 8 rising edges per byte. sclk ends low.
- Arithmetic:
  - Divider counter: 4 bits, wraps at CLK_DIV-1.
  - Bit counter: 3 bits, increments on each falling edge.
  - Gap counter: 4 bits.
- Reset, including mid-transaction:
  - Outputs: cs_n=1, sclk=0, mosi=0, gnt=0, done=0, busy=0, rx_data=8'h00.
  - State: FSM=IDLE, last_gnt=1.
  - No done is emitted for an aborted byte.

## Timing
- req high in IDLE at cycle n → gnt and cs_n=0 registered at n+1.
- wr at cycle m (in GRANT) → SHIFT entry at m+1, with mosi=tx[7] valid at m+1.
  - First sclk rise at m+1+CLK_DIV.
  - done at m+1+16*CLK_DIV. With CLK_DIV=2 that is m+33.
  - rx_data updates in the same cycle as done.
- Back-to-back bytes: the earliest next wr is the done cycle+1.
- req drops at cycle k in GRANT → gnt=0 and cs_n=1 at k+1. The next grant is no earlier than k+1+CS_GAP+1.
- A req drop during SHIFT takes effect at the done cycle+1.
- cs_n setup to the first sclk rise is at least CLK_DIV+1 cycles.
- cs_n hold after the last sclk fall is at least 1 cycle.
- All outputs are registered. No combinational input→output paths.

## Structure
- Package spi0_arbiter_pkg:
  - state enum {IDLE, GRANT, SHIFT, GAP}.
  - Requester index constants REQ_CPU=0, REQ_DMA=1.
  - Default CLK_DIV/CS_GAP localparams.
- Sub-module spi_byte_engine:
  - Contents: divider, bit counter, shift registers, sclk/mosi regs.
  - Ports: start/tx in; done/rx out; miso/sclk/mosi.
  - The arbiter top owns the FSM, grant and round-robin state, and cs_n.

## Test plan
- **Reset:** NRST=0 for 3 cycles during a SHIFT → next cycle cs_n=1, sclk=0, gnt=00, busy=0, no done.
- **Single byte:** req0, wr0 with tx0=8'hA5, miso looping mosi, CLK_DIV=2:
  - mosi bits 1,0,1,0,0,1,0,1 and 8 sclk rises.
  - done0 at wr+33 with rx_data=8'hA5.
  - cs_n low throughout.
- **Tie and round-robin:** req0 and req1 raised in the same cycle → gnt0 first. Then:
  - Drop req0 → cs_n high for exactly 4 cycles.
  - gnt1 follows.
  - Repeat the simultaneous request → gnt0 again.
- **Ignored strobes:** wr1 with tx1=8'hFF while gnt0 is held, and wr0 during SHIFT → no extra byte, no done1, mosi pattern unchanged.
- **Mid-byte release:** req0 dropped at the 3rd sclk rise → byte completes and done0 pulses. Then cs_n=1 on the next cycle, followed by GAP.
- **Multi-byte:** 3 bytes 8'h03, 8'h00, 8'h10 with wr issued 1 cycle after each done, miso driven 8'h3C for each byte → cs_n stays low throughout, three done0 pulses spaced 34 cycles apart, rx_data=8'h3C at each.

Source files
------------

// File: rtl/spi0_arbiter_pkg.sv
// Shared types and defaults for the SPI0 two-requester arbiter.
package spi0_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, SHIFT, GAP} state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    localparam int DEF_CLK_DIV = 2;
    localparam int DEF_CS_GAP  = 4;

endpackage

// File: rtl/spi0_arbiter_byte_engine.sv
// SPI mode-0 byte engine: MSB first, miso sampled on sclk rise, mosi advanced on fall.
module spi_byte_engine
    import spi0_arbiter_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic       clk_4x,
    input  logic       NRST,
    input  logic       start,
    input  logic [7:0] tx,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       done,
    output logic [7:0] rx
);

    logic       active;
    logic       tick;
    logic [3:0] div_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] tx_sh;
    logic [7:0] rx_sh;

    assign tick = (div_cnt == 4'(CLK_DIV - 1));

    always_ff @(posedge clk_4x) begin
        if (!NRST) begin
            active <= 1'b0;
            sclk   <= 1'b0;
            mosi   <= 1'b0;
            done   <= 1'b0;
            rx     <= 8'h00;
        end else begin
            done <= 1'b0;
            if (start) begin
                active <= 1'b1;
                mosi   <= tx[7];
            end else if (active && tick) begin
                sclk <= ~sclk;
                if (sclk) begin
                    // falling edge: either the byte is finished or the next bit goes out
                    if (bit_cnt == 3'd7) begin
                        active <= 1'b0;
                        done   <= 1'b1;
                        rx     <= rx_sh;
                    end else begin
                        mosi <= tx_sh[6];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_4x) begin
        if (start) begin
            tx_sh   <= tx;
            div_cnt <= 4'd0;
            bit_cnt <= 3'd0;
        end else if (active) begin
            div_cnt <= tick ? 4'd0 : div_cnt + 4'd1;
            if (tick) begin
                if (!sclk) begin
                    rx_sh <= {rx_sh[6:0], miso};
                end else begin
                    tx_sh   <= {tx_sh[6:0], 1'b0};
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/spi0_arbiter.sv
// Round-robin arbiter sharing the SPI0 pads between the CPU peripheral and the DMA loader.
module spi0_arbiter
    import spi0_arbiter_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int CS_GAP  = DEF_CS_GAP
) (
    input  logic       clk_4x,
    input  logic       NRST,
    input  logic       req0,
    input  logic       req1,
    input  logic       wr0,
    input  logic       wr1,
    input  logic [7:0] tx0,
    input  logic [7:0] tx1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_cs_n
);

    state_t     state, state_nxt;
    logic       owner, owner_nxt;
    logic       last_gnt, last_gnt_nxt;
    logic [3:0] gap_cnt, gap_cnt_nxt;
    logic       hold;
    logic       req_g, wr_g, start, eng_done;
    logic [7:0] tx_g;

    assign req_g = (owner == REQ_DMA) ? req1 : req0;
    assign wr_g  = (owner == REQ_DMA) ? wr1  : wr0;
    assign tx_g  = (owner == REQ_DMA) ? tx1  : tx0;
    // a release in the same cycle as a strobe wins: no byte is started
    assign start = (state == GRANT) && req_g && wr_g;

    assign done0 = eng_done && (owner == REQ_CPU);
    assign done1 = eng_done && (owner == REQ_DMA);

    always_ff @(posedge clk_4x) begin
        if (!NRST) begin
            state    <= IDLE;
            owner    <= REQ_CPU;
            last_gnt <= REQ_DMA;
            gap_cnt  <= 4'd0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            spi_cs_n <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            last_gnt <= last_gnt_nxt;
            gap_cnt  <= gap_cnt_nxt;
            gnt0     <= hold && (owner_nxt == REQ_CPU);
            gnt1     <= hold && (owner_nxt == REQ_DMA);
            spi_cs_n <= !hold;
            busy     <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        last_gnt_nxt = last_gnt;
        gap_cnt_nxt  = gap_cnt;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nxt    = GRANT;
                    owner_nxt    = (req0 && req1) ? ~last_gnt : req1;
                    last_gnt_nxt = owner_nxt;
                end
            end
            GRANT: begin
                if (!req_g) begin
                    state_nxt   = GAP;
                    gap_cnt_nxt = 4'd0;
                end else if (wr_g) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (eng_done) begin
                    state_nxt   = req_g ? GRANT : GAP;
                    gap_cnt_nxt = 4'd0;
                end
            end
            GAP: begin
                if (gap_cnt == 4'(CS_GAP - 1)) state_nxt = IDLE;
                else gap_cnt_nxt = gap_cnt + 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
        hold = (state_nxt == GRANT) || (state_nxt == SHIFT);
    end

    spi_byte_engine #(.CLK_DIV(CLK_DIV)) u_engine (
        .clk_4x (clk_4x),
        .NRST   (NRST),
        .start  (start),
        .tx     (tx_g),
        .miso   (spi_miso),
        .sclk   (spi_sclk),
        .mosi   (spi_mosi),
        .done   (eng_done),
        .rx     (rx_data)
    );

endmodule

// File: tb/tb_spi0_arbiter.sv
// Directed bench for spi0_arbiter: byte vectors table plus arbitration/reset sequences.
module tb_spi0_arbiter;

    logic       clk_4x = 1'b0;
    logic       NRST;
    logic       req0, req1, wr0, wr1;
    logic [7:0] tx0, tx1;
    logic       gnt0, gnt1, done0, done1, busy;
    logic [7:0] rx_data;
    logic       spi_sclk, spi_mosi, spi_miso, spi_cs_n;

    int tests = 0;
    int fails = 0;

    spi0_arbiter #(.CLK_DIV(2), .CS_GAP(4)) dut (
        .clk_4x   (clk_4x),
        .NRST     (NRST),
        .req0     (req0),
        .req1     (req1),
        .wr0      (wr0),
        .wr1      (wr1),
        .tx0      (tx0),
        .tx1      (tx1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .done0    (done0),
        .done1    (done1),
        .rx_data  (rx_data),
        .busy     (busy),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_cs_n (spi_cs_n)
    );

    always #5 clk_4x = ~clk_4x;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] pat;
        bit         loop;
        bit         poke;
        logic [7:0] exp_mosi;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Runs one byte for requester rq starting at the current negedge (the wr cycle).
    // Returns at the negedge of the done cycle, or after a 40-cycle budget.
    task automatic run_byte(input bit rq, input logic [7:0] tx, input logic [7:0] pat,
                            input bit loop, input bit poke, input bit rel,
                            input logic [7:0] exp_mosi, input logic [7:0] exp_rx);
        int         rises;
        int         done_at;
        logic [7:0] cap;
        logic       prev;
        bit         other_done;
        bit         cs_hi;
        chk("cs_low_at_wr", {31'd0, spi_cs_n}, 32'd0);
        if (rq) begin wr1 = 1'b1; tx1 = tx; end
        else    begin wr0 = 1'b1; tx0 = tx; end
        @(negedge clk_4x);
        wr0 = 1'b0; wr1 = 1'b0; tx0 = 8'h00; tx1 = 8'h00;
        chk("mosi_first_bit", {31'd0, spi_mosi}, {31'd0, tx[7]});
        rises = 0; done_at = -1; cap = 8'h00; prev = 1'b0;
        other_done = 1'b0; cs_hi = 1'b0;
        for (int c = 1; c <= 40 && done_at < 0; c++) begin
            if (spi_sclk && !prev) begin
                rises++;
                cap = {cap[6:0], spi_mosi};
                if (rel && rises == 3) begin
                    if (rq) req1 = 1'b0; else req0 = 1'b0;
                end
            end
            prev = spi_sclk;
            if (rises < 8) spi_miso = loop ? spi_mosi : pat[7 - rises];
            if (spi_cs_n) cs_hi = 1'b1;
            if (rq ? done0 : done1) other_done = 1'b1;
            if (rq ? done1 : done0) done_at = c;
            if (poke && c == 5) begin
                wr0 = 1'b1; wr1 = 1'b1;
                if (rq) begin tx1 = 8'h00; tx0 = 8'hFF; end
                else    begin tx0 = 8'h00; tx1 = 8'hFF; end
            end
            if (poke && c == 6) begin
                wr0 = 1'b0; wr1 = 1'b0; tx0 = 8'h00; tx1 = 8'h00;
            end
            if (done_at < 0) @(negedge clk_4x);
        end
        chk("done_cycle", done_at, 33);
        chk("sclk_rises", rises, 8);
        chk("mosi_bits", {24'd0, cap}, {24'd0, exp_mosi});
        chk("rx_data", {24'd0, rx_data}, {24'd0, exp_rx});
        chk("sclk_low_at_done", {31'd0, spi_sclk}, 32'd0);
        chk("no_foreign_done", {31'd0, other_done}, 32'd0);
        chk("cs_held_low", {31'd0, cs_hi}, 32'd0);
    endtask

    initial begin
        int  gap;
        int  got;
        bit  flag;

        vt[0] = '{8'hA5, 8'h00, 1'b1, 1'b0, 8'hA5, 8'hA5};
        vt[1] = '{8'h03, 8'h3C, 1'b0, 1'b0, 8'h03, 8'h3C};
        vt[2] = '{8'h00, 8'h3C, 1'b0, 1'b1, 8'h00, 8'h3C};
        vt[3] = '{8'h10, 8'h3C, 1'b0, 1'b0, 8'h10, 8'h3C};
        vt[4] = '{8'h81, 8'h5A, 1'b0, 1'b0, 8'h81, 8'h5A};

        NRST = 1'b0; req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        tx0 = 8'h00; tx1 = 8'h00; spi_miso = 1'b0;
        repeat (3) @(negedge clk_4x);
        chk("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
        chk("rst_sclk", {31'd0, spi_sclk}, 32'd0);
        chk("rst_mosi", {31'd0, spi_mosi}, 32'd0);
        chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {30'd0, done1, done0}, 32'd0);
        chk("rst_rx", {24'd0, rx_data}, 32'd0);
        NRST = 1'b1;
        @(negedge clk_4x);

        // simultaneous requests: req0 wins the first tie
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clk_4x);
        chk("tie1_gnt", {30'd0, gnt1, gnt0}, 32'd1);
        chk("tie1_cs_n", {31'd0, spi_cs_n}, 32'd0);
        chk("tie1_busy", {31'd0, busy}, 32'd1);

        // strobe from the non-granted requester starts nothing
        wr1 = 1'b1; tx1 = 8'hFF;
        @(negedge clk_4x);
        wr1 = 1'b0; tx1 = 8'h00;
        flag = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (spi_sclk || done1 || done0) flag = 1'b1;
            @(negedge clk_4x);
        end
        chk("ignored_wr1", {31'd0, flag}, 32'd0);

        // back-to-back bytes in one transaction, wr one cycle after each done
        for (int v = 0; v < 5; v++) begin
            if (v > 0) @(negedge clk_4x);
            run_byte(1'b0, vt[v].tx, vt[v].pat, vt[v].loop, vt[v].poke, 1'b0,
                     vt[v].exp_mosi, vt[v].exp_rx);
        end
        @(negedge clk_4x);
        chk("post_table_gnt0", {31'd0, gnt0}, 32'd1);

        // release req0 while req1 waits: gap then gnt1
        req0 = 1'b0;
        gap = 0; got = -1;
        for (int c = 1; c <= 20 && got < 0; c++) begin
            @(negedge clk_4x);
            if (c == 1) begin
                chk("rel_gnt0_off", {31'd0, gnt0}, 32'd0);
                chk("rel_cs_high", {31'd0, spi_cs_n}, 32'd1);
            end
            if (spi_cs_n && busy) gap++;
            if (gnt1) got = c;
        end
        chk("gap_cycles", gap, 4);
        chk("regrant_delay", got, 6);
        chk("gnt1_cs_low", {31'd0, spi_cs_n}, 32'd0);

        run_byte(1'b1, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5A, 8'h5A);

        req1 = 1'b0;
        got = -1;
        for (int c = 1; c <= 20 && got < 0; c++) begin
            @(negedge clk_4x);
            if (!busy) got = c;
        end
        chk("idle_after_dma", {31'd0, busy}, 32'd0);
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clk_4x);
        chk("tie2_gnt", {30'd0, gnt1, gnt0}, 32'd1);

        // req0 released at the third sclk rise: byte still completes
        @(negedge clk_4x);
        run_byte(1'b0, 8'hC3, 8'h00, 1'b1, 1'b0, 1'b1, 8'hC3, 8'hC3);
        @(negedge clk_4x);
        chk("midrel_cs_high", {31'd0, spi_cs_n}, 32'd1);
        chk("midrel_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        chk("midrel_gap_busy", {31'd0, busy}, 32'd1);

        got = -1;
        for (int c = 1; c <= 20 && got < 0; c++) begin
            @(negedge clk_4x);
            if (gnt1) got = c;
        end
        chk("gnt1_after_midrel", {31'd0, gnt1}, 32'd1);

        // reset in the middle of a byte
        wr1 = 1'b1; tx1 = 8'hA5;
        @(negedge clk_4x);
        wr1 = 1'b0; tx1 = 8'h00;
        repeat (9) @(negedge clk_4x);
        chk("shift_busy", {31'd0, busy}, 32'd1);
        NRST = 1'b0; req1 = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_4x);
            if (done0 || done1) flag = 1'b1;
        end
        NRST = 1'b1;
        chk("mrst_no_done", {31'd0, flag}, 32'd0);
        chk("mrst_cs_n", {31'd0, spi_cs_n}, 32'd1);
        chk("mrst_sclk", {31'd0, spi_sclk}, 32'd0);
        chk("mrst_mosi", {31'd0, spi_mosi}, 32'd0);
        chk("mrst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_rx", {24'd0, rx_data}, 32'd0);

        req0 = 1'b1; req1 = 1'b1;
        @(negedge clk_4x);
        chk("tie_after_rst", {30'd0, gnt1, gnt0}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
